// File: rtl/led_trail_pwm_pkg.sv
// Shared constants, types and helpers for the LED comet-tail PWM stage.
// The gamma-mapped duty path is selected at build time with LED_GAMMA_EN.
package led_pkg;

  localparam int LED_N_DEFAULT    = 8;
  localparam int PWM_BITS_DEFAULT = 4;

  // Full-scale brightness for a given PWM resolution.
  function automatic int br_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int BR_MAX_DEFAULT = br_max(PWM_BITS_DEFAULT);

  typedef logic [PWM_BITS_DEFAULT-1:0] br_t;

endpackage

// File: rtl/led_trail_pwm_if.sv
// LED pattern in, PWM drive and frame marker out.
interface led_trail_pwm_if #(
  parameter int N_LED = 8
);
  logic [N_LED-1:0] led_in;
  logic [N_LED-1:0] led_out;
  logic             pwm_wrap;

  modport master (
    output led_in,
    input  led_out,
    input  pwm_wrap
  );

  modport slave (
    input  led_in,
    output led_out,
    output pwm_wrap
  );
endinterface

// File: rtl/led_trail_pwm_ch.sv
// One LED channel: brightness register with load/decay, duty mapping, output compare.
// LED_GAMMA_EN selects a squared (gamma) duty curve instead of linear.
module led_pwm_ch
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEFAULT,
  parameter int DECAY_STEP = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_head,
  input  logic                i_decay_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] BR_MAX_W = PWM_BITS'(br_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP_W   = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] r_br;
  logic [PWM_BITS-1:0] w_br_nxt;
  logic [PWM_BITS-1:0] w_duty;
  logic                r_led;

  // Head load beats decay; decay saturates at zero.
  always_comb begin
    w_br_nxt = r_br;
    if (i_head) begin
      w_br_nxt = BR_MAX_W;
    end else if (i_decay_tick) begin
      if (r_br > STEP_W) begin
        w_br_nxt = r_br - STEP_W;
      end else begin
        w_br_nxt = {PWM_BITS{1'b0}};
      end
    end else begin
      w_br_nxt = r_br;
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_br_ext;
  logic [2*PWM_BITS-1:0] w_prod;

  assign w_br_ext = {{PWM_BITS{1'b0}}, r_br};
  assign w_prod   = w_br_ext * w_br_ext;

  // Squared curve; full scale is pinned so a head LED stays solidly on.
  always_comb begin
    w_duty = {PWM_BITS{1'b0}};
    if (r_br == BR_MAX_W) begin
      w_duty = BR_MAX_W;
    end else begin
      w_duty = PWM_BITS'(w_prod >> PWM_BITS);
    end
  end
`else
  assign w_duty = r_br;
`endif

  // Brightness state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br <= {PWM_BITS{1'b0}};
    end else begin
      r_br <= w_br_nxt;
    end
  end

  // Registered PWM compare against the shared frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= 1'b0;
    end else begin
      r_led <= (i_pwm_cnt < w_duty);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-tail LED driver: decay prescaler, shared PWM frame counter, N_LED channels.
// Build with LED_GAMMA_EN for gamma-mapped duty in every channel.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LED      = LED_N_DEFAULT,
  parameter int PWM_BITS   = PWM_BITS_DEFAULT,
  parameter int DECAY_DIV  = 400000,
  parameter int DECAY_STEP = 3
) (
  input  logic            clk,
  input  logic            rst,
  led_trail_pwm_if.slave  bus
);

  localparam int                  PRESC_W    = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] BR_MAX_W   = PWM_BITS'(br_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] CNT_LAST   = BR_MAX_W - PWM_BITS'(1);

  logic [PRESC_W-1:0]  r_presc;
  logic                w_decay_tick;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_pwm_wrap;
  logic [N_LED-1:0]    w_led;

  assign w_decay_tick = (r_presc == PRESC_LAST);

  // Decay prescaler, 0..DECAY_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= {PRESC_W{1'b0}};
    end else if (w_decay_tick) begin
      r_presc <= {PRESC_W{1'b0}};
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // PWM frame counter runs 0..BR_MAX-1 so duty=BR_MAX is always on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwm_cnt  <= {PWM_BITS{1'b0}};
      r_pwm_wrap <= 1'b0;
    end else begin
      r_pwm_wrap <= (r_pwm_cnt == CNT_LAST);
      if (r_pwm_cnt == CNT_LAST) begin
        r_pwm_cnt <= {PWM_BITS{1'b0}};
      end else begin
        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_pwm_ch #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_head       (bus.led_in[g]),
      .i_decay_tick (w_decay_tick),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_led        (w_led[g])
    );
  end

  assign bus.led_out  = w_led;
  assign bus.pwm_wrap = r_pwm_wrap;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: two instances (step 3 / div 4, step 7 / div 32) against a frame-level model.
// Honours LED_GAMMA_EN for the expected duty curve.
module tb_led_trail_pwm;

  logic clk;
  logic rst;

  led_trail_pwm_if #(.N_LED(8)) if1 ();
  led_trail_pwm_if #(.N_LED(8)) if2 ();

  led_trail_pwm #(.N_LED(8), .PWM_BITS(4), .DECAY_DIV(4), .DECAY_STEP(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  led_trail_pwm #(.N_LED(8), .PWM_BITS(4), .DECAY_DIV(32), .DECAY_STEP(7)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, brightness per channel per instance.
  int e = 0;
  int br1 [8];
  int br2 [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input int b);
`ifdef LED_GAMMA_EN
    if (b == 15) return 15;
    return (b * b) / 16;
`else
    return b;
`endif
  endfunction

  function automatic int sat_sub(input int b, input int s);
    return (b > s) ? b - s : 0;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 8; i++) begin
      br1[i] = 0;
      br2[i] = 0;
    end
  endtask

  // One clock: drive pattern, advance model, sample both instances after the edge.
  task automatic step(input logic [7:0] din);
    logic [7:0] exp1;
    logic [7:0] exp2;
    int p;
    if1.led_in = din;
    if2.led_in = din;
    @(posedge clk);
    e++;
    p = (e - 1) % 15;
    for (int i = 0; i < 8; i++) begin
      exp1[i] = (p < duty_of(br1[i]));
      exp2[i] = (p < duty_of(br2[i]));
      if (din[i]) begin
        br1[i] = 15;
        br2[i] = 15;
      end else begin
        if (e % 4 == 0)  br1[i] = sat_sub(br1[i], 3);
        if (e % 32 == 0) br2[i] = sat_sub(br2[i], 7);
      end
    end
    #1;
    check("led_out1", if1.led_out, exp1);
    check("wrap1", if1.pwm_wrap, (p == 14));
    check("led_out2", if2.led_out, exp2);
    check("wrap2", if2.pwm_wrap, (p == 14));
  endtask

  // Assert reset between edges, verify outputs clear before any edge, release mid-cycle.
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    check("rst_led1", if1.led_out, 8'h00);
    check("rst_wrap1", if1.pwm_wrap, 1'b0);
    check("rst_led2", if2.led_out, 8'h00);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    int first_wrap;
    int k;
    int cnt;
    logic [7:0] r;

    rst = 1'b0;
    if1.led_in = 8'h00;
    if2.led_in = 8'h00;
    model_reset();
    #1;
    check("init_led1", if1.led_out, 8'h00);
    check("init_wrap1", if1.pwm_wrap, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Reset mid-run while a head is lit.
    repeat (20) step(8'h01);
    check("pre_rst_led1", if1.led_out, 8'h01);
    do_reset();

    // Hold, and time the first frame marker after release.
    first_wrap = 0;
    for (int n = 1; n <= 30; n++) begin
      step(8'h01);
      if (first_wrap == 0 && if1.pwm_wrap) first_wrap = n;
    end
    check("first_wrap", first_wrap, 15);
    check("hold_led1", if1.led_out, 8'h01);

    // Decay of the tail down to dark.
    repeat (30) step(8'h00);
    check("decayed_led1", if1.led_out, 8'h00);

    // Collision: reload channel 3 on a tick while it sits at 12.
    k = 0;
    while (((e + 1) % 4) != 0 && k < 8) begin
      step(8'h00);
      k++;
    end
    step(8'h08);
    repeat (7) step(8'h00);
    step(8'h08);
    for (int n = 0; n < 4; n++) begin
      step(8'h00);
      check("collision_led3", if1.led_out[3], 1'b1);
    end

    // Instance 2: 15 -> 8 on one tick, then measure a whole frame.
    step(8'h20);
    k = 0;
    do begin
      step(8'h00);
      k++;
    end while ((e % 32) != 0 && k < 40);
    k = 0;
    while (!if2.pwm_wrap && k < 20) begin
      step(8'h00);
      k++;
    end
    check("wrap2_found", (k < 20), 1'b1);
    cnt = 0;
    repeat (15) begin
      step(8'h00);
      cnt += int'(if2.led_out[5]);
    end
`ifdef LED_GAMMA_EN
    check("frame_br8", cnt, 4);
`else
    check("frame_br8", cnt, 8);
`endif

    // 8 -> 1 -> 0 must saturate, never wrap back up.
    repeat (100) step(8'h00);
    check("saturated_led2", if2.led_out, 8'h00);

    // Randomised heads: mostly single one-hot, sometimes several at once.
    repeat (800) begin
      case ($urandom_range(0, 5))
        0:       r = 8'h01 << $urandom_range(0, 7);
        1:       r = 8'($urandom);
        default: r = 8'h00;
      endcase
      step(r);
    end

    // Reset again mid-activity, then a short random tail.
    do_reset();
    repeat (60) step(($urandom_range(0, 3) == 0) ? (8'h80 >> $urandom_range(0, 7)) : 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
